// File: rtl/execute_cycle.sv
`default_nettype none
// execute_cycle: E stage - operand forwarding, ALU, branch resolution and the E/M pipeline register.
// Define MUL_EN to build the iterative shift-add multiplier, which stalls upstream through BusyE.
module execute_cycle #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            ResultSrcE,
    input  logic            ALUSrcE,
    input  logic            BranchE,
    input  logic            MulE,
    input  logic [2:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [4:0]      RD_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [1:0]      ForwardA_E,
    input  logic [1:0]      ForwardB_E,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            BusyE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            ResultSrcM,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] ALU_ResultM
);
    logic [XLEN-1:0] src_a, write_data, src_b, alu_result;
    logic            zero, alu_lt;
    logic            mul_bubble, mul_done;
    logic [XLEN-1:0] mul_product;

    always_comb begin
        case (ForwardA_E)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALU_ResultM;
            default: src_a = RD1_E;
        endcase
        case (ForwardB_E)
            2'b01:   write_data = ResultW;
            2'b10:   write_data = ALU_ResultM;
            default: write_data = RD2_E;
        endcase
    end

    assign src_b  = ALUSrcE ? Imm_Ext_E : write_data;
    assign alu_lt = $signed(src_a) < $signed(src_b);

    always_comb begin
        case (ALUControlE)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b101:  alu_result = {{(XLEN-1){1'b0}}, alu_lt};
            default: alu_result = '0;
        endcase
    end

    assign zero      = (alu_result == '0);
    assign PCTargetE = PCE + Imm_Ext_E;

`ifdef MUL_EN
    localparam int               CNT_W     = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_CYCLES - 1);
    localparam logic [0:0]       S_IDLE    = 1'b0;
    localparam logic [0:0]       S_BUSY    = 1'b1;

    logic [0:0]       state, state_next;
    logic [CNT_W-1:0] mul_count;
    logic [XLEN-1:0]  mul_mcand, mul_mplier, mul_acc, mul_sum;
    logic             mul_start, mul_last;

    assign mul_last    = (mul_count == LAST_ITER);
    assign mul_sum     = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;
    assign mul_product = mul_sum;
    assign PCSrcE      = BranchE & zero & ~MulE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (MulE)     state_next = S_BUSY;
            S_BUSY:  if (mul_last) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mul_start  = 1'b0;
        mul_bubble = 1'b0;
        mul_done   = 1'b0;
        BusyE      = 1'b0;
        case (state)
            S_IDLE: if (MulE) begin
                mul_start  = 1'b1;
                mul_bubble = 1'b1;
                BusyE      = 1'b1;
            end
            S_BUSY: if (mul_last) begin
                mul_done   = 1'b1;
            end else begin
                mul_bubble = 1'b1;
                BusyE      = 1'b1;
            end
            default: ;
        endcase
        // The stall must drop as soon as reset is applied, even with MulE still high
        if (!rst) BusyE = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_count  <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_acc    <= '0;
        end else if (mul_start) begin
            mul_count  <= '0;
            mul_mcand  <= src_a;
            mul_mplier <= src_b;
            mul_acc    <= '0;
        end else if (state == S_BUSY) begin
            mul_count  <= mul_last ? '0 : mul_count + 1'b1;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_acc    <= mul_sum;
        end
    end
`else
    logic unused_mul;
    assign unused_mul  = MulE ^ (MUL_CYCLES != XLEN);
    assign BusyE       = 1'b0;
    assign mul_bubble  = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
    assign PCSrcE      = BranchE & zero;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= '0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
        end else if (mul_bubble) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= '0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
        end else if (mul_done) begin
            RegWriteM   <= RegWriteE;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= ResultSrcE;
            RD_M        <= RD_E;
            PCPlus4M    <= PCPlus4E;
            WriteDataM  <= '0;
            ALU_ResultM <= mul_product;
        end else begin
            RegWriteM   <= RegWriteE;
            MemWriteM   <= MemWriteE;
            ResultSrcM  <= ResultSrcE;
            RD_M        <= RD_E;
            PCPlus4M    <= PCPlus4E;
            WriteDataM  <= write_data;
            ALU_ResultM <= alu_result;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_execute_cycle.sv
`default_nettype none
// tb_execute_cycle: randomized self-checking bench for execute_cycle against a behavioural model.
module tb_execute_cycle;
`ifdef MUL_EN
    localparam bit MUL_BUILD = 1'b1;
`else
    localparam bit MUL_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, MulE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    wire         PCSrcE, BusyE, RegWriteM, MemWriteM, ResultSrcM;
    wire  [31:0] PCTargetE, PCPlus4M, WriteDataM, ALU_ResultM;
    wire  [4:0]  RD_M;
    wire [103:0] em_act = {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM};

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [103:0] exp_em  = '0;

    always #5 clk = ~clk;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .ALUSrcE(ALUSrcE), .BranchE(BranchE), .MulE(MulE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .BusyE(BusyE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM)
    );

    // Reference model: operand selection uses the model's own prediction of ALU_ResultM
    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd);
        case (sel)
            2'b01:   return ResultW;
            2'b10:   return exp_em[31:0];
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] ref_src_b();
        return ALUSrcE ? Imm_Ext_E : fwd(ForwardB_E, RD2_E);
    endfunction

    function automatic logic [103:0] ref_em();
        logic [31:0] a, wd, b, r;
        a  = fwd(ForwardA_E, RD1_E);
        wd = fwd(ForwardB_E, RD2_E);
        b  = ALUSrcE ? Imm_Ext_E : wd;
        case (ALUControlE)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd5:    r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return {RegWriteE, MemWriteE, ResultSrcE, RD_E, PCPlus4E, wd, r};
    endfunction

    task automatic rand_inputs();
        RegWriteE   = 1'($urandom);
        MemWriteE   = 1'($urandom);
        ResultSrcE  = 1'($urandom);
        ALUSrcE     = 1'($urandom);
        BranchE     = 1'($urandom);
        MulE        = MUL_BUILD ? 1'b0 : 1'($urandom);
        ALUControlE = 3'($urandom);
        RD1_E       = $urandom;
        RD2_E       = $urandom;
        Imm_Ext_E   = $urandom;
        RD_E        = 5'($urandom);
        PCE         = $urandom;
        PCPlus4E    = PCE + 32'd4;
        ForwardA_E  = 2'($urandom);
        ForwardB_E  = 2'($urandom);
        ResultW     = $urandom;
        if ($urandom_range(0, 3) == 0) begin
            ForwardA_E  = 2'b00;
            ForwardB_E  = 2'b00;
            RD2_E       = RD1_E;
            ALUSrcE     = 1'b0;
            ALUControlE = 3'b001;
        end
    endtask

    task automatic test_reset();
        rand_inputs();
        MulE = MUL_BUILD;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_checks++;
            if ({em_act, BusyE} !== 105'd0) begin
                n_fail++;
                $display("FAIL reset_state: got em=%h busy=%b, expected all zero", em_act, BusyE);
            end
            @(posedge clk); #1;
        end
        MulE   = 1'b0;
        rst    = 1'b1;
        exp_em = '0;
    endtask

    task automatic test_random_alu(input int n);
        logic [103:0] e;
        logic         exp_br;
        for (int i = 0; i < n; i++) begin
            rand_inputs();
            #2;
            e      = ref_em();
            exp_br = BranchE && (e[31:0] == 32'd0) && !(MUL_BUILD && MulE);
            n_checks++;
            if ({PCSrcE, PCTargetE, BusyE} !== {exp_br, PCE + Imm_Ext_E, 1'b0}) begin
                n_fail++;
                $display("FAIL alu_comb: got pcsrc=%b target=%h busy=%b, expected pcsrc=%b target=%h busy=0",
                         PCSrcE, PCTargetE, BusyE, exp_br, PCE + Imm_Ext_E);
            end
            @(posedge clk); #1;
            n_checks++;
            if (em_act !== e) begin
                n_fail++;
                $display("FAIL alu_em: got %h expected %h (op=%0d)", em_act, e, ALUControlE);
            end
            exp_em = e;
        end
    endtask

    task automatic test_forward_add();
        logic [103:0] e;
        rand_inputs();
        RD1_E = 32'd5; ForwardA_E = 2'b01; ResultW = 32'd10;
        Imm_Ext_E = 32'd3; ALUSrcE = 1'b1; ALUControlE = 3'b000;
        #2;
        e = ref_em();
        @(posedge clk); #1;
        n_checks++;
        if ({ALU_ResultM, RD_M} !== {32'd13, RD_E}) begin
            n_fail++;
            $display("FAIL fwd_add: got result=%0d rd=%0d expected result=13 rd=%0d", ALU_ResultM, RD_M, RD_E);
        end
        exp_em = e;
    endtask

    task automatic test_branch();
        logic [103:0] e;
        rand_inputs();
        BranchE = 1'b1; ALUControlE = 3'b001; RD1_E = 32'd7; RD2_E = 32'd7;
        ForwardA_E = 2'b00; ForwardB_E = 2'b00; ALUSrcE = 1'b0; MulE = 1'b0;
        PCE = 32'h100; Imm_Ext_E = 32'h20;
        #2;
        n_checks++;
        if ({PCSrcE, PCTargetE} !== {1'b1, 32'h120}) begin
            n_fail++;
            $display("FAIL branch_taken: got pcsrc=%b target=%h expected pcsrc=1 target=00000120", PCSrcE, PCTargetE);
        end
        e = ref_em();
        @(posedge clk); #1;
        exp_em = e;
    endtask

    task automatic test_slt();
        logic [103:0] e;
        for (int s = 0; s < 2; s++) begin
            rand_inputs();
            ALUControlE = 3'b101; ForwardA_E = 2'b00; ForwardB_E = 2'b00; ALUSrcE = 1'b0;
            RD1_E = (s == 0) ? 32'hFFFF_FFFF : 32'd1;
            RD2_E = (s == 0) ? 32'd1 : 32'hFFFF_FFFF;
            #2;
            e = ref_em();
            @(posedge clk); #1;
            n_checks++;
            if (ALU_ResultM !== ((s == 0) ? 32'd1 : 32'd0)) begin
                n_fail++;
                $display("FAIL slt_signed: got %0d expected %0d (case %0d)", ALU_ResultM, (s == 0) ? 1 : 0, s);
            end
            exp_em = e;
        end
    endtask

`ifdef MUL_EN
    task automatic test_mul(input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] fa, input logic use_imm);
        logic [31:0] prod;
        int          busy_cycles;
        bit          done;
        rand_inputs();
        MulE = 1'b1; BranchE = 1'b1; ALUControlE = 3'b100;
        RD1_E = a; ForwardA_E = fa;
        if (fa == 2'b01) ResultW = a;
        ALUSrcE = use_imm; ForwardB_E = 2'b00;
        if (use_imm) Imm_Ext_E = b; else RD2_E = b;
        prod = fwd(ForwardA_E, RD1_E) * ref_src_b();
        #2;
        n_checks++;
        if (PCSrcE !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_pcsrc: got %b expected 0", PCSrcE);
        end
        busy_cycles = 0;
        done        = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (BusyE === 1'b1) begin
                busy_cycles++;
                @(posedge clk); #1;
                n_checks++;
                if (em_act !== 104'd0) begin
                    n_fail++;
                    $display("FAIL mul_bubble: got %h expected all zero (busy cycle %0d)", em_act, busy_cycles);
                end
                ResultW = $urandom;
                #2;
            end else begin
                @(posedge clk); #1;
                n_checks++;
                if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, ALU_ResultM} !==
                    {RegWriteE, 1'b0, ResultSrcE, RD_E, PCPlus4E, prod}) begin
                    n_fail++;
                    $display("FAIL mul_result: got rw=%b mw=%b rd=%0d result=%h expected rw=%b mw=0 rd=%0d result=%h",
                             RegWriteM, MemWriteM, RD_M, ALU_ResultM, RegWriteE, RD_E, prod);
                end
                done = 1'b1;
            end
        end
        n_checks++;
        if (!done || busy_cycles != 32) begin
            n_fail++;
            $display("FAIL mul_busy_len: got %0d busy cycles (done=%0d) expected 32", busy_cycles, done);
        end
        exp_em = {RegWriteE, 1'b0, ResultSrcE, RD_E, PCPlus4E, 32'd0, prod};
    endtask

    task automatic test_multiply();
        test_mul(32'd7, 32'd6, 2'b00, 1'b0);
        test_mul(32'hFFFF_FFFF, 32'd3, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++)
            test_mul($urandom, $urandom, 2'($urandom_range(0, 2)), 1'($urandom));
    endtask

    task automatic test_mul_reset();
        logic [103:0] e;
        rand_inputs();
        MulE = 1'b1; ALUSrcE = 1'b0; ForwardA_E = 2'b00; ForwardB_E = 2'b00;
        repeat (11) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (BusyE !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_reset_pre: got busy=%b expected 1", BusyE);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({em_act, BusyE} !== 105'd0) begin
            n_fail++;
            $display("FAIL mul_reset_now: got em=%h busy=%b expected all zero", em_act, BusyE);
        end
        @(posedge clk); #1;
        exp_em = '0;
        rand_inputs();
        ALUControlE = 3'b000;
        rst = 1'b1;
        #2;
        n_checks++;
        if (BusyE !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_reset_busy: got %b expected 0", BusyE);
        end
        e = ref_em();
        @(posedge clk); #1;
        n_checks++;
        if (em_act !== e) begin
            n_fail++;
            $display("FAIL mul_reset_add: got %h expected %h", em_act, e);
        end
        exp_em = e;
    endtask

    task automatic test_back_to_back();
        test_mul($urandom, $urandom, 2'b10, 1'b0);
        test_mul($urandom, $urandom, 2'b10, 1'b1);
        test_random_alu(2);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_forward_add();
        test_branch();
        test_slt();
        test_random_alu(60);
`ifdef MUL_EN
        test_multiply();
        test_back_to_back();
        test_mul_reset();
        test_random_alu(10);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute (E) stage of the 5-stage pipeline; sits between the decode stage and the memory stage.
- Selects forwarded operands, runs the ALU, and resolves branches (PCSrcE, PCTargetE).
- Registers all E-stage results into the E/M pipeline register that drives the memory stage.
- Optionally contains an iterative 32-cycle multiplier; it stalls upstream through BusyE while a multiply is in progress.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- MUL_CYCLES, 32, number of multiplier iterations. Must equal XLEN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE  in  1 each  decode control signals.
- MulE  in  1  the instruction in E is a multiply.
- ALUControlE  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt (signed). Other codes produce 0.
- RD1_E, RD2_E  in  32  register-file read data.
- Imm_Ext_E  in  32  sign-extended immediate.
- RD_E  in  5  destination register.
- PCE, PCPlus4E  in  32  PC of the E instruction, and PC+4.
- ForwardA_E, ForwardB_E  in  2  operand select: 00 register data, 01 ResultW, 10 ALU_ResultM, 11 register data.
- ResultW  in  32  writeback result, used for forwarding.
- PCSrcE  out  1  branch taken. Combinational.
- PCTargetE  out  32  PCE + Imm_Ext_E. Combinational.
- BusyE  out  1  stall request to the hazard unit. Combinational.
- RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered control signals.
- RD_M  out  5  registered destination register.
- PCPlus4M, WriteDataM, ALU_ResultM  out  32  registered data.

Behaviour:
- Single clock clk. Reset rst is asynchronous and active-low.
- While rst=0:
  - All registered outputs are 0.
  - FSM is in IDLE; iteration counter is 0; BusyE is 0.
- SrcA is the ForwardA_E mux output. WriteData is the ForwardB_E mux output. SrcB = ALUSrcE ? Imm_Ext_E : WriteData.
- ALU arithmetic:
  - Add and sub wrap modulo 2^32.
  - slt returns 1 when signed(SrcA) < signed(SrcB), otherwise 0.
  - Zero = (ALU result == 0).
- PCSrcE = BranchE & Zero. PCSrcE is forced to 0 when MulE=1.
- Non-multiply instructions: one-cycle latency. At each rising edge the E/M register captures RegWriteE, MemWriteE, ResultSrcE, RD_E, PCPlus4E, WriteData and the ALU result.
- Multiplier FSM states: IDLE, BUSY.
  - IDLE with MulE=1:
    - BusyE=1 (combinational).
    - At the edge: latch SrcA as the multiplicand and SrcB as the multiplier; clear the accumulator and counter; go to BUSY.
    - The E/M register loads a bubble: all controls 0, all data 0.
  - BUSY: each cycle performs one shift-add step (if multiplier bit0 is set, add the multiplicand into the accumulator; shift the multiplicand left and the multiplier right) and increments the counter.
    - BusyE=1 while counter < MUL_CYCLES-1.
    - While counter < MUL_CYCLES-1, the E/M register loads a bubble.
  - BUSY with counter == MUL_CYCLES-1:
    - BusyE=0.
    - At the edge: the E/M register loads the final low 32 bits of the product as ALU_ResultM, together with the multiply's RegWriteE/ResultSrcE/RD_E/PCPlus4E and MemWriteM=0.
    - FSM returns to IDLE.
  - Total E occupancy of a multiply is 33 cycles. Upstream holds the E inputs stable while BusyE=1.
- Operands are latched on entry, so later changes to ResultW or ALU_ResultM do not affect the product.
- Product is the low 32 bits, which are identical for signed and unsigned operands.
- Back-to-back multiplies: the second multiply is seen in IDLE on the cycle after the first writes back, and starts normally.
- Reset asserted mid-multiply aborts the operation: state goes to IDLE and no result is written.

Optional Feature:
- Macro: MUL_EN.
- Defined: the multiplier FSM and BusyE behave as described above.
- Not defined:
  - No multiplier logic is built; BusyE is tied to 0.
  - MulE is ignored, and the instruction executes as its ALUControlE op with one-cycle latency.

Test Plan:
- Forwarding and add: RD1_E=5, ForwardA_E=01, ResultW=10, Imm_Ext_E=3, ALUSrcE=1, ALUControlE=000 -> next cycle ALU_ResultM=13 and RD_M=RD_E.
- Branch taken: BranchE=1, sub with SrcA=SrcB=7, PCE=0x100, Imm_Ext_E=0x20 -> PCSrcE=1 and PCTargetE=0x120 in the same cycle.
- Signed slt: SrcA=0xFFFFFFFF, SrcB=1 -> ALU_ResultM=1. Swapped operands -> ALU_ResultM=0.
- Multiply 7*6 (MUL_EN defined):
  - BusyE high for exactly 32 cycles.
  - 32 bubbles with RegWriteM=0.
  - Then ALU_ResultM=42 with RegWriteM=1.
- Multiply 0xFFFFFFFF*3 -> ALU_ResultM=0xFFFFFFFD.
- Reset mid-multiply: pull rst low at counter=10 -> outputs 0 and BusyE=0 immediately. After rst is released, the next add completes in 1 cycle.
